osc_voice_mixer: RTL

OSC_VOICE_MIXER -- requirements
Module: osc_voice_mixer

---
 rtl/osc_voice_mixer_pkg.sv | 8 +
 rtl/osc_voice_mixer_mult.sv | 38 +++
 rtl/osc_voice_mixer.sv | 102 ++++++++++
 3 files changed

// File: rtl/osc_voice_mixer_pkg.sv
// osc_voice_mixer_pkg: shared widths and sequencer state encoding for the voice mixer
package osc_voice_mixer_pkg;
    localparam int SAMPLE_W = 17;
    localparam int LEVEL_W  = 8;
    localparam int SUM_W    = 19;

    typedef enum logic {EXPECT0, ACCUM} seq_state_t;
endpackage

// File: rtl/osc_voice_mixer_mult.sv
// osc_level_mult: registered signed sample times unsigned level, scaled down by 256
module osc_level_mult
    import osc_voice_mixer_pkg::*;
#(
    parameter int V_WIDTH = 3,
    parameter int O_WIDTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [SAMPLE_W-1:0] sine_in,
    input  logic                       sine_valid,
    input  logic        [V_WIDTH-1:0]  sine_vx,
    input  logic        [O_WIDTH-1:0]  sine_ox,
    input  logic        [LEVEL_W-1:0]  osc_level,
    output logic signed [SAMPLE_W-1:0] prod,
    output logic                       prod_valid,
    output logic        [V_WIDTH-1:0]  prod_vx,
    output logic        [O_WIDTH-1:0]  prod_ox
);
    logic signed [SAMPLE_W+LEVEL_W:0] full;

    assign full = sine_in * $signed({1'b0, osc_level});

    // |full >>> 8| never exceeds 65280, so the 17-bit truncation is lossless
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod       <= '0;
            prod_valid <= 1'b0;
            prod_vx    <= '0;
            prod_ox    <= '0;
        end else begin
            prod       <= SAMPLE_W'(full >>> 8);
            prod_valid <= sine_valid;
            prod_vx    <= sine_vx;
            prod_ox    <= sine_ox;
        end
    end
endmodule

// File: rtl/osc_voice_mixer.sv
// osc_voice_mixer: sums V_OSC level-scaled oscillator samples per voice, flags sequence errors
module osc_voice_mixer
    import osc_voice_mixer_pkg::*;
#(
    parameter int VOICES  = 8,
    parameter int V_OSC   = 4,
    parameter int V_WIDTH = 3,
    parameter int O_WIDTH = 2
) (
    input  logic                       sCLK_XVXENVS,
    input  logic                       reset_reg,
    input  logic signed [SAMPLE_W-1:0] sine_in,
    input  logic                       sine_valid,
    input  logic        [V_WIDTH-1:0]  sine_vx,
    input  logic        [O_WIDTH-1:0]  sine_ox,
    input  logic        [LEVEL_W-1:0]  osc_level,
    input  logic        [VOICES-1:0]   voice_free,
    input  logic                       clear_err,
    output logic signed [SUM_W-1:0]    voice_sum,
    output logic                       voice_valid,
    output logic        [V_WIDTH-1:0]  voice_vx,
    output logic                       seq_err
);
    logic signed [SAMPLE_W-1:0] prod;
    logic                       prod_valid;
    logic        [V_WIDTH-1:0]  prod_vx;
    logic        [O_WIDTH-1:0]  prod_ox;

    seq_state_t                 state, state_nx;
    logic        [O_WIDTH-1:0]  exp_ox, exp_nx;
    logic signed [SUM_W-1:0]    acc, acc_nx, pext, psum;
    logic        [V_WIDTH-1:0]  lvx, lvx_nx;
    logic                       accept, done, start, err;

    osc_level_mult #(.V_WIDTH(V_WIDTH), .O_WIDTH(O_WIDTH)) u_mult (
        .clk        (sCLK_XVXENVS),
        .rst        (reset_reg),
        .sine_in    (sine_in),
        .sine_valid (sine_valid),
        .sine_vx    (sine_vx),
        .sine_ox    (sine_ox),
        .osc_level  (osc_level),
        .prod       (prod),
        .prod_valid (prod_valid),
        .prod_vx    (prod_vx),
        .prod_ox    (prod_ox)
    );

    always_comb begin
        pext     = {{(SUM_W-SAMPLE_W){prod[SAMPLE_W-1]}}, prod};
        psum     = acc + pext;
        accept   = prod_valid && state == ACCUM && prod_ox == exp_ox && prod_vx == lvx;
        done     = accept && prod_ox == O_WIDTH'(V_OSC-1);
        start    = prod_valid && !accept && prod_ox == '0;
        err      = prod_valid && !accept && !(state == EXPECT0 && prod_ox == '0);
        state_nx = state;
        exp_nx   = exp_ox;
        acc_nx   = acc;
        lvx_nx   = lvx;
        if (done) begin
            state_nx = EXPECT0;
            exp_nx   = '0;
            acc_nx   = '0;
        end else if (accept) begin
            acc_nx = psum;
            exp_nx = exp_ox + O_WIDTH'(1);
        end else if (start) begin
            state_nx = ACCUM;
            acc_nx   = pext;
            lvx_nx   = prod_vx;
            exp_nx   = O_WIDTH'(1);
        end else if (prod_valid) begin
            state_nx = EXPECT0;
            exp_nx   = '0;
            acc_nx   = '0;
        end
    end

    always_ff @(posedge sCLK_XVXENVS or posedge reset_reg) begin
        if (reset_reg) begin
            state       <= EXPECT0;
            exp_ox      <= '0;
            acc         <= '0;
            lvx         <= '0;
            voice_sum   <= '0;
            voice_vx    <= '0;
            voice_valid <= 1'b0;
            seq_err     <= 1'b0;
        end else begin
            state       <= state_nx;
            exp_ox      <= exp_nx;
            acc         <= acc_nx;
            lvx         <= lvx_nx;
            voice_valid <= done;
            seq_err     <= err | (seq_err & ~clear_err);
            if (done) begin
                voice_sum <= voice_free[lvx] ? '0 : psum;
                voice_vx  <= lvx;
            end
        end
    end
endmodule
